// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache between the CPU data port and DataMemory.
// Refills whole four-word lines and forwards every store to memory for one cycle.
module cache_controller #(
    parameter int unsigned WORD      = 32,
    parameter int unsigned ADDRESSL  = 15,
    parameter int unsigned BLOCKSIZE = 4,
    parameter int unsigned INDEXL    = 10,
    parameter int unsigned MISS_WAIT = 4
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic [ADDRESSL-1:0]       cpuAddress,
    input  logic                      cpuRead,
    input  logic                      cpuWrite,
    input  logic [WORD-1:0]           cpuWriteData,
    output logic [WORD-1:0]           cpuData,
    output logic                      ready,
    output logic [ADDRESSL-1:0]       memAddress,
    output logic [ADDRESSL-1:0]       memAddress0,
    output logic [ADDRESSL-1:0]       memAddress1,
    output logic [ADDRESSL-1:0]       memAddress2,
    output logic [ADDRESSL-1:0]       memAddress3,
    output logic                      memRead,
    output logic                      memWrite,
    output logic [WORD-1:0]           memWriteData,
    input  logic [BLOCKSIZE*WORD-1:0] memBlock,
    output logic [31:0]               accessCount,
    output logic [31:0]               hitCount
);

    localparam int unsigned TagW  = ADDRESSL - INDEXL - 2;
    localparam int unsigned Lines = 2 ** INDEXL;
    localparam int unsigned WaitW = $clog2(MISS_WAIT + 1);

    typedef enum logic [1:0] {StIdle, StFill, StWrite} cacheState;

    cacheState stateQ, stateD;
    logic [WaitW-1:0] waitCntQ, waitCntD;
    logic             missPendingQ, missPendingD;
    logic [31:0]      accessCountQ, accessCountD;
    logic [31:0]      hitCountQ, hitCountD;

    logic [BLOCKSIZE-1:0][WORD-1:0] lineArr [Lines];
    logic [TagW-1:0]                tagArr [Lines];
    logic [Lines-1:0]               validArr;

    logic [1:0]        offset;
    logic [INDEXL-1:0] index;
    logic [TagW-1:0]   tag;
    logic              hit;
    logic [WORD-1:0]   hitWord;
    logic              fillEn;
    logic              writeHitEn;

    assign offset  = cpuAddress[1:0];
    assign index   = cpuAddress[INDEXL+1:2];
    assign tag     = cpuAddress[ADDRESSL-1:INDEXL+2];
    assign hit     = validArr[index] && (tagArr[index] == tag);
    assign hitWord = lineArr[index][offset];

    assign memAddress   = cpuAddress;
    assign memWriteData = cpuWriteData;
    assign memAddress0  = {cpuAddress[ADDRESSL-1:2], 2'd0};
    assign memAddress1  = {cpuAddress[ADDRESSL-1:2], 2'd1};
    assign memAddress2  = {cpuAddress[ADDRESSL-1:2], 2'd2};
    assign memAddress3  = {cpuAddress[ADDRESSL-1:2], 2'd3};
    assign accessCount  = accessCountQ;
    assign hitCount     = hitCountQ;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stateQ       <= StIdle;
            waitCntQ     <= '0;
            missPendingQ <= 1'b0;
            accessCountQ <= '0;
            hitCountQ    <= '0;
        end else begin
            stateQ       <= stateD;
            waitCntQ     <= waitCntD;
            missPendingQ <= missPendingD;
            accessCountQ <= accessCountD;
            hitCountQ    <= hitCountD;
        end
    end

    // Only the valid bits need reset; tag and data contents are don't-care while invalid.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            validArr <= '0;
        end else if (fillEn) begin
            validArr[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fillEn) begin
            lineArr[index] <= memBlock;
            tagArr[index]  <= tag;
        end else if (writeHitEn) begin
            lineArr[index][offset] <= cpuWriteData;
        end
    end

    always_comb begin
        stateD       = stateQ;
        waitCntD     = waitCntQ;
        missPendingD = missPendingQ;
        accessCountD = accessCountQ;
        hitCountD    = hitCountQ;
        ready        = 1'b0;
        cpuData      = '0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        fillEn       = 1'b0;
        writeHitEn   = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (cpuWrite) begin
                    stateD = StWrite;
                end else if (cpuRead) begin
                    if (hit) begin
                        ready        = 1'b1;
                        cpuData      = hitWord;
                        accessCountD = accessCountQ + 32'd1;
                        // The hit that completes a refilled read is not a first-lookup hit.
                        if (!missPendingQ) hitCountD = hitCountQ + 32'd1;
                        missPendingD = 1'b0;
                    end else begin
                        waitCntD     = WaitW'(MISS_WAIT - 1);
                        missPendingD = 1'b1;
                        stateD       = StFill;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            StFill: begin
                memRead = 1'b1;
                if (waitCntQ == '0) begin
                    fillEn = 1'b1;
                    stateD = StIdle;
                end else begin
                    waitCntD = waitCntQ - WaitW'(1);
                end
            end
            StWrite: begin
                memWrite   = 1'b1;
                ready      = 1'b1;
                writeHitEn = hit;
                stateD     = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus random reads/writes
// against a tag/valid reference model and a reference memory image.
module tb_cache_controller;

    localparam int MissWait = 4;

    logic          clk = 1'b0;
    logic          rstN;
    logic [14:0]   cpuAddress;
    logic          cpuRead, cpuWrite;
    logic [31:0]   cpuWriteData, cpuData;
    logic          ready;
    logic [14:0]   memAddress, memAddress0, memAddress1, memAddress2, memAddress3;
    logic          memRead, memWrite;
    logic [31:0]   memWriteData;
    logic [127:0]  memBlock;
    logic [31:0]   accessCount, hitCount;

    logic [31:0] mem    [32768];
    logic [31:0] refMem [32768];
    bit          refValid [1024];
    logic [2:0]  refTag   [1024];
    int          refAcc, refHit;
    int          nChecks = 0, nFail = 0;

    cache_controller #(.MISS_WAIT(MissWait)) dut (
        .clk(clk), .rstN(rstN), .cpuAddress(cpuAddress), .cpuRead(cpuRead),
        .cpuWrite(cpuWrite), .cpuWriteData(cpuWriteData), .cpuData(cpuData), .ready(ready),
        .memAddress(memAddress), .memAddress0(memAddress0), .memAddress1(memAddress1),
        .memAddress2(memAddress2), .memAddress3(memAddress3), .memRead(memRead),
        .memWrite(memWrite), .memWriteData(memWriteData), .memBlock(memBlock),
        .accessCount(accessCount), .hitCount(hitCount)
    );

    always #5 clk = ~clk;

    // DataMemory stand-in: combinational block read, store on the clock edge.
    assign memBlock = {mem[memAddress3], mem[memAddress2], mem[memAddress1], mem[memAddress0]};
    always @(posedge clk) if (memWrite) mem[memAddress] <= memWriteData;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 1024; i++) refValid[i] = 1'b0;
        refAcc = 0;
        refHit = 0;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic doRead(input logic [14:0] a);
        int  lowCycles = 0;
        int  rdCycles  = 0;
        bit  expHit;
        expHit = refValid[a[11:2]] && (refTag[a[11:2]] == a[14:12]);
        cpuAddress = a;
        cpuRead    = 1'b1;
        @(negedge clk);
        while (!ready && lowCycles < 50) begin
            if (memRead) begin
                if (rdCycles == 0) begin
                    check("fillAddr0", 32'(memAddress0), 32'({a[14:2], 2'd0}));
                    check("fillAddr3", 32'(memAddress3), 32'({a[14:2], 2'd3}));
                end
                rdCycles++;
            end
            lowCycles++;
            @(negedge clk);
        end
        check("rdLatency", 32'(lowCycles), expHit ? 32'd0 : 32'(MissWait + 1));
        check("rdMemReadCycles", 32'(rdCycles), expHit ? 32'd0 : 32'(MissWait));
        check("rdData", cpuData, refMem[a]);
        @(posedge clk);
        #1;
        cpuRead = 1'b0;
        refAcc++;
        if (expHit) refHit++;
        refValid[a[11:2]] = 1'b1;
        refTag[a[11:2]]   = a[14:12];
        check("accessCount", accessCount, 32'(refAcc));
        check("hitCount", hitCount, 32'(refHit));
    endtask

    task automatic doWrite(input logic [14:0] a, input logic [31:0] d);
        cpuAddress   = a;
        cpuWriteData = d;
        cpuWrite     = 1'b1;
        @(negedge clk);
        check("wrReadyLow", 32'(ready), 32'd0);
        check("wrMemWriteEarly", 32'(memWrite), 32'd0);
        @(negedge clk);
        check("wrReadyHigh", 32'(ready), 32'd1);
        check("wrMemWrite", 32'(memWrite), 32'd1);
        check("wrNoMemRead", 32'(memRead), 32'd0);
        check("wrAddr", 32'(memAddress), 32'(a));
        check("wrData", memWriteData, d);
        @(posedge clk);
        #1;
        cpuWrite = 1'b0;
        refMem[a] = d;
        @(negedge clk);
        check("wrMemWriteDrop", 32'(memWrite), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [14:0] a;
        logic [31:0] d;
        for (int i = 0; i < 32768; i++) begin
            mem[i]    = $urandom;
            refMem[i] = mem[i];
        end
        mem[15'h0010]    = 32'h1111_1111;
        refMem[15'h0010] = 32'h1111_1111;
        for (int i = 0; i < 1024; i++) refTag[i] = 3'd0;
        resetModel();
        rstN = 1'b0;
        cpuAddress = '0;
        cpuRead = 1'b0;
        cpuWrite = 1'b0;
        cpuWriteData = '0;
        repeat (2) @(negedge clk);
        check("rstReady", 32'(ready), 32'd1);
        check("rstCpuData", cpuData, 32'd0);
        check("rstMemRead", 32'(memRead), 32'd0);
        check("rstMemWrite", 32'(memWrite), 32'd0);
        check("rstAccess", accessCount, 32'd0);
        check("rstHit", hitCount, 32'd0);
        @(posedge clk);
        #1;
        rstN = 1'b1;

        // Directed scenarios: cold miss, hit, conflict, write hit, write miss.
        doRead(15'h0010);
        doRead(15'h0011);
        doRead(15'h1010);
        doRead(15'h0010);
        check("planAccess", accessCount, 32'd4);
        check("planHit", hitCount, 32'd1);
        doWrite(15'h0011, 32'hDEAD_BEEF);
        doRead(15'h0011);
        doWrite(15'h0200, 32'hCAFE_F00D);
        doRead(15'h0200);
        @(negedge clk);
        check("idleCpuData", cpuData, 32'd0);
        check("idleReady", 32'(ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset in the second FILL cycle.
        cpuAddress = 15'h0400;
        cpuRead    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("fill2MemRead", 32'(memRead), 32'd1);
        rstN = 1'b0;
        #1;
        check("abortMemRead", 32'(memRead), 32'd0);
        check("abortAccess", accessCount, 32'd0);
        check("abortHit", hitCount, 32'd0);
        cpuRead = 1'b0;
        resetModel();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        doRead(15'h0011);

        // Random traffic over a small footprint so hits, conflicts and write hits all occur.
        for (int n = 0; n < 120; n++) begin
            a = {3'($urandom_range(0, 1)), 10'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            d = $urandom;
            if ($urandom_range(0, 9) < 7) doRead(a);
            else doWrite(a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", nChecks);
        $fatal(1, "timeout");
    end

endmodule
